// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_pkg : shared types and constants for the sequential multiplier  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mult_pkg;

  localparam int MULT_W    = 32;
  localparam int MULT_ITER = 32;
  localparam int CNT_W     = $clog2(MULT_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(MULT_ITER - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_seq_if : operand/start/result bundle of the sequential multiplier|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface mult_seq_if;
  import mult_pkg::*;

  logic [MULT_W-1:0] srcA;
  logic [MULT_W-1:0] srcB;
  logic              multCtrl;
  logic [MULT_W-1:0] hi;
  logic [MULT_W-1:0] lo;
  logic              multBusy;
  logic              multDone;

  modport master (
    output srcA, srcB, multCtrl,
    input  hi, lo, multBusy, multDone
  );

  modport slave (
    input  srcA, srcB, multCtrl,
    output hi, lo, multBusy, multDone
  );

endinterface
`default_nettype wire

// File: rtl/mult_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_step : one add/sub-and-shift iteration of the multiplier        |
// | Config    : MULT_SIGNED_EN selects radix-2 Booth (signed) datapath   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module mult_step
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] mcand,
  input  logic [MULT_W-1:0] acc,
  input  logic [MULT_W-1:0] mplr,
`ifdef MULT_SIGNED_EN
  input  logic              qm1,
  output logic              qm1_nxt,
`endif
  output logic [MULT_W-1:0] acc_nxt,
  output logic [MULT_W-1:0] mplr_nxt
);

  // One guard bit: carry (unsigned) or true sign (signed) shifted back into acc
  logic [MULT_W:0] sum;

`ifdef MULT_SIGNED_EN
  logic [MULT_W:0] acc_x;
  logic [MULT_W:0] mcand_x;

  always_comb begin
    acc_x   = {acc[MULT_W-1], acc};
    mcand_x = {mcand[MULT_W-1], mcand};
    sum     = acc_x;
    unique case ({mplr[0], qm1})
      2'b01:   sum = acc_x + mcand_x;
      2'b10:   sum = acc_x - mcand_x;
      default: sum = acc_x;
    endcase
  end

  assign qm1_nxt = mplr[0];
`else
  always_comb begin
    sum = {1'b0, acc};
    if (mplr[0]) begin
      sum = {1'b0, acc} + {1'b0, mcand};
    end
  end
`endif

  assign acc_nxt  = sum[MULT_W:1];
  assign mplr_nxt = {sum[0], mplr[MULT_W-1:1]};

endmodule
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_seq : 32x32 -> 64 sequential multiplier, one bit per cycle      |
// | Config   : MULT_SIGNED_EN = signed Booth, otherwise unsigned         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module mult_seq
  import mult_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mult_seq_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  logic [MULT_W-1:0] mcand;
  logic [MULT_W-1:0] acc;
  logic [MULT_W-1:0] mplr;
  logic [MULT_W-1:0] hi_q;
  logic [MULT_W-1:0] lo_q;
  logic [MULT_W-1:0] acc_step;
  logic [MULT_W-1:0] mplr_step;
  logic [CNT_W-1:0]  cnt;
  logic              last;
`ifdef MULT_SIGNED_EN
  logic              qm1;
  logic              qm1_step;
`endif

  assign last = is_last_iter(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start strobe in any state (including RUN) restarts the operation
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.multCtrl) state_nxt = RUN;
      RUN:     if (!bus.multCtrl && last) state_nxt = DONE;
      DONE:    state_nxt = bus.multCtrl ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mult_step u_step (
    .mcand    (mcand),
    .acc      (acc),
    .mplr     (mplr),
`ifdef MULT_SIGNED_EN
    .qm1      (qm1),
    .qm1_nxt  (qm1_step),
`endif
    .acc_nxt  (acc_step),
    .mplr_nxt (mplr_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef MULT_SIGNED_EN
      qm1   <= 1'b0;
`endif
    end else if (bus.multCtrl) begin
      mcand <= bus.srcA;
      mplr  <= bus.srcB;
      acc   <= '0;
      cnt   <= '0;
`ifdef MULT_SIGNED_EN
      qm1   <= 1'b0;
`endif
    end else if (state == RUN) begin
      acc  <= acc_step;
      mplr <= mplr_step;
      cnt  <= cnt + CNT_W'(1);
`ifdef MULT_SIGNED_EN
      qm1  <= qm1_step;
`endif
      // Result registers move only on the final iteration
      if (last) begin
        hi_q <= acc_step;
        lo_q <= mplr_step;
      end
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.multBusy = (state == RUN);
  assign bus.multDone = (state == DONE);

endmodule
`default_nettype wire

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port srcA, input, 32 bits: multiplicand, sampled only on start.
REQ-004 The block SHALL have port srcB, input, 32 bits: multiplier, sampled only on start.
REQ-005 The block SHALL have port multCtrl, input, 1 bit: start (MultInit) strobe.
REQ-006 The block SHALL have port hi, output, 32 bits: upper half of the 64-bit product.
REQ-007 The block SHALL have port lo, output, 32 bits: lower half of the 64-bit product.
REQ-008 The block SHALL have port multBusy, output, 1 bit: high while iterating.
REQ-009 The block SHALL have port multDone, output, 1 bit: one-cycle pulse when hi/lo are updated with a new result.

Function
REQ-010 The state machine SHALL have the states IDLE, RUN and DONE.
REQ-011 From IDLE or DONE, multCtrl=1 at edge N SHALL load srcA/srcB into internal registers, clear the accumulator and the iteration counter, and enter RUN.
REQ-012 RUN SHALL perform exactly one iteration per cycle, 32 iterations in total, on edges N+1..N+32.
REQ-013 Each iteration SHALL update a 65-bit working register {acc[31:0], mplr[31:0], q-1}: conditional add/sub of the multiplicand into acc, then a 1-bit right shift.
REQ-014 On edge N+32, hi/lo SHALL take {acc, mplr}, multDone SHALL assert for the cycle after N+32, and the state SHALL become DONE.
REQ-015 DONE SHALL return to IDLE after one cycle unless multCtrl=1, which starts a new operation.
REQ-016 hi/lo SHALL change only at completion or reset; they hold the previous result throughout RUN.
REQ-017 multBusy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-018 multCtrl=1 during RUN SHALL abort the current operation and restart with new operands (re-latch, counter cleared); hi/lo keep their old values and no multDone is issued for the aborted operation.
REQ-019 multCtrl held high for several cycles SHALL re-trigger the load each cycle; iteration begins in the first cycle with multCtrl=0.
REQ-020 Operand zero SHALL NOT shortcut: latency is always 32 iteration cycles.
REQ-021 All arithmetic SHALL be modulo 2^32 within acc; the 64-bit result SHALL be exact (no overflow flag).

Reset
REQ-022 reset=1 at an edge SHALL force IDLE and set hi=0, lo=0, multBusy=0 and multDone=0, and clear all internal registers.
REQ-023 reset SHALL have priority over multCtrl, and reset mid-RUN SHALL discard the operation with no multDone.

Configuration
REQ-024 With MULT_SIGNED_EN defined, the block SHALL use radix-2 Booth recoding: pair (mplr[0], q-1) = 01 adds, 10 subtracts, 00/11 do nothing, followed by an arithmetic right shift, giving a two's-complement signed product.
REQ-025 Without MULT_SIGNED_EN, the block SHALL perform unsigned shift-add: mplr[0]=1 adds with the carry kept in the 65th bit, followed by a logical right shift, giving an unsigned product; q-1 is unused.

Structure
REQ-026 A shared package mult_pkg SHALL hold the state enum (IDLE/RUN/DONE), the constant MULT_W=32 and the iteration count MULT_ITER=32.
REQ-027 The single-iteration combinational datapath (add/sub select plus shift) SHALL be the sub-module mult_step, instantiated once.

Verification
REQ-028 With srcA=7 and srcB=6, a start pulse SHALL produce, 32 cycles later, multDone=1, hi=0x00000000 and lo=0x0000002A.
REQ-029 With MULT_SIGNED_EN, srcA=0xFFFFFFFD (-3) and srcB=5 SHALL give hi=0xFFFFFFFF and lo=0xFFFFFFF1; with srcA=srcB=0x80000000 the result SHALL be hi=0x40000000, lo=0x00000000.
REQ-030 Without MULT_SIGNED_EN, srcA=srcB=0xFFFFFFFF SHALL give hi=0xFFFFFFFE and lo=0x00000001.
REQ-031 Starting 9*9 after a prior result of 42, then reset at iteration 10, SHALL produce multBusy=0, hi=lo=0 and no multDone pulse.
REQ-032 Starting 2*3, then issuing multCtrl at iteration 15 with srcA=4 and srcB=5, SHALL produce exactly one multDone, 32 cycles after the second start, with lo=20; hi/lo SHALL hold the old values until then.
